tdc_multi_core: RTL

Parametrised multi-channel successor of the single-channel TDC core: measures high time (in clock cycles) of up to 16 independent discriminator inputs and tags each pulse with the leading-edge timestamp. Completed measurements are arbitrated round-robin into one shared 32-bit first-word-fall-through FIFO read by the readout fabric, next to the other data sources. Sits behind `bus_to_ip` like every core; one clock domain.

---
 rtl/tdc_multi_core_if.sv | 24 ++
 rtl/tdc_multi_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_multi_core_if.sv
// Register-bus and readout-FIFO signal bundle of tdc_multi_core.
// The master side is the bus bridge plus readout fabric; the slave side is the core.
interface tdc_multi_core_if #(
    parameter int ABUSWIDTH = 16
);
    logic [ABUSWIDTH-1:0] BUS_ADD;
    logic [7:0]           BUS_DATA_IN;
    logic [7:0]           BUS_DATA_OUT;
    logic                 BUS_RD;
    logic                 BUS_WR;
    logic                 FIFO_READ;
    logic                 FIFO_EMPTY;
    logic [31:0]          FIFO_DATA;

    modport master (
        output BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, FIFO_READ,
        input  BUS_DATA_OUT, FIFO_EMPTY, FIFO_DATA
    );

    modport slave (
        input  BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, FIFO_READ,
        output BUS_DATA_OUT, FIFO_EMPTY, FIFO_DATA
    );
endinterface

// File: rtl/tdc_multi_core.sv
// Multi-channel TDC: per-channel pulse width + leading-edge timestamp, round-robin into a shared FWFT FIFO.
// Define TDC_MULTI_GLITCH_FILTER_EN to require two stable samples before an input edge is recognised.
module tdc_multi_core #(
    parameter int         CHANNELS        = 4,
    parameter int         DEPTH           = 512,
    parameter logic [3:0] DATA_IDENTIFIER = 4'b0100,
    parameter int         ABUSWIDTH       = 16
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    tdc_multi_core_if.slave     bus,
    input  logic [CHANNELS-1:0] TDC_IN,
    input  logic                ARM_TDC,
    input  logic                EXT_EN,
    input  logic [15:0]         TIMESTAMP
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, MEASURE} ch_state_t;
    typedef logic [ABUSWIDTH-1:0] addr_t;

    // Control registers and counters
    logic        en, en_arm, en_ext;
    logic [15:0] mask;
    logic [15:0] word_cnt;
    logic [7:0]  word_cnt_hi;
    logic [7:0]  lost_cnt, lost_nxt;
    logic [8:0]  lost_sum;
    logic [7:0]  data_out;
    logic        soft_rst;
    logic        gate;

    // Input conditioning
    logic [CHANNELS-1:0] s1, s2, s3;
    logic [CHANNELS-1:0] samp, rise, fall;

    // Channel measurement state
    ch_state_t   st     [CHANNELS];
    ch_state_t   st_nxt [CHANNELS];
    logic [11:0] ts     [CHANNELS];
    logic [11:0] ts_nxt [CHANNELS];
    logic [11:0] width     [CHANNELS];
    logic [11:0] width_nxt [CHANNELS];
    logic [CHANNELS-1:0] done;

    // Pending slots and arbiter
    logic [CHANNELS-1:0] slot_full;
    logic [23:0]         slot_data [CHANNELS];
    logic [CHANNELS-1:0] grant_oh, drop, accept;
    logic                grant_vld;
    logic [IW-1:0]       grant_idx, last_grant;

    // FIFO
    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop, can_write;
    logic [31:0] wr_word;

    logic unused_ts;
    assign unused_ts = ^TIMESTAMP[15:12];

    assign soft_rst = bus.BUS_WR && (bus.BUS_ADD == addr_t'(0));
    assign gate     = en & (~en_arm | ARM_TDC) & (~en_ext | EXT_EN);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            en     <= 1'b0;
            en_arm <= 1'b0;
            en_ext <= 1'b0;
            mask   <= '1;
        end else if (bus.BUS_WR) begin
            case (bus.BUS_ADD)
                addr_t'(1): {en_ext, en_arm, en} <= bus.BUS_DATA_IN[2:0];
                addr_t'(2): mask[7:0]            <= bus.BUS_DATA_IN;
                addr_t'(3): mask[15:8]           <= bus.BUS_DATA_IN;
                default: ;
            endcase
        end
    end

    // Reading the low count byte freezes the high byte so a 16-bit value is read coherently.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            data_out    <= '0;
            word_cnt_hi <= '0;
        end else begin
            if (soft_rst) word_cnt_hi <= '0;
            if (bus.BUS_RD) begin
                case (bus.BUS_ADD)
                    addr_t'(1): data_out <= {5'b0, en_ext, en_arm, en};
                    addr_t'(2): data_out <= mask[7:0];
                    addr_t'(3): data_out <= mask[15:8];
                    addr_t'(4): begin
                        data_out    <= word_cnt[7:0];
                        word_cnt_hi <= word_cnt[15:8];
                    end
                    addr_t'(5): data_out <= word_cnt_hi;
                    addr_t'(6): data_out <= lost_cnt;
                    addr_t'(7): data_out <= 8'd1;
                    default:    data_out <= '0;
                endcase
            end
        end
    end

    assign bus.BUS_DATA_OUT = data_out;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= TDC_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef TDC_MULTI_GLITCH_FILTER_EN
    logic [CHANNELS-1:0] filt;

    // The filtered level follows s3 only once s2 agrees, so a one-sample excursion never lands.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            filt <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (s2[i] == s3[i]) filt[i] <= s3[i];
            end
        end
    end

    assign samp = s3;
    assign rise = s3 & s2 & ~filt;
    assign fall = ~s3 & ~s2 & filt;
`else
    assign samp = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
`endif

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            st_nxt[i]    = st[i];
            ts_nxt[i]    = ts[i];
            width_nxt[i] = width[i];
            done[i]      = 1'b0;
            case (st[i])
                IDLE: begin
                    if (rise[i] && gate && mask[i]) begin
                        st_nxt[i]    = MEASURE;
                        ts_nxt[i]    = TIMESTAMP[11:0];
                        width_nxt[i] = 12'd1;
                    end
                end
                MEASURE: begin
                    if (!gate) begin
                        st_nxt[i] = IDLE;
                    end else if (fall[i]) begin
                        done[i]   = 1'b1;
                        st_nxt[i] = IDLE;
                    end else if (samp[i] && (width[i] != 12'hFFF)) begin
                        width_nxt[i] = width[i] + 12'd1;
                    end
                end
                default: st_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]    <= IDLE;
                ts[i]    <= '0;
                width[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]    <= soft_rst ? IDLE : st_nxt[i];
                ts[i]    <= ts_nxt[i];
                width[i] <= width_nxt[i];
            end
        end
    end

    // Search starts one past the last grant, so a constantly busy channel cannot starve the rest.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = last_grant;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_vld && can_write && slot_full[idx[IW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx[IW-1:0];
            end
        end
    end

    // A slot being granted this cycle is free again, so a new completion may refill it.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == IW'(i));
        end
        drop     = done & slot_full & ~grant_oh;
        accept   = done & ~drop;
        lost_sum = {1'b0, lost_cnt};
        for (int i = 0; i < CHANNELS; i++) begin
            lost_sum = lost_sum + 9'(drop[i]);
        end
        lost_nxt = (lost_sum > 9'd255) ? 8'hFF : lost_sum[7:0];
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            slot_full  <= '0;
            lost_cnt   <= '0;
            last_grant <= IW'(CHANNELS - 1);
            for (int i = 0; i < CHANNELS; i++) slot_data[i] <= '0;
        end else if (soft_rst) begin
            slot_full  <= '0;
            lost_cnt   <= '0;
            last_grant <= IW'(CHANNELS - 1);
        end else begin
            lost_cnt <= lost_nxt;
            if (grant_vld) last_grant <= grant_idx;
            for (int i = 0; i < CHANNELS; i++) begin
                if (accept[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_data[i] <= {ts[i], width[i]};
                end else if (grant_oh[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = bus.FIFO_READ && !fifo_empty;
    assign can_write  = !fifo_full || pop;
    assign push       = grant_vld;
    assign wr_word    = {DATA_IDENTIFIER, 4'(grant_idx), slot_data[grant_idx]};

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_cnt <= '0;
        end else if (soft_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                word_cnt <= word_cnt + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which words are valid.
    always_ff @(posedge BUS_CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_word;
    end

    assign bus.FIFO_EMPTY = fifo_empty;
    assign bus.FIFO_DATA  = fifo_empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
endmodule
